// File: rtl/hash_block_sequencer.sv
// Streams 1..MAX_BLOCKS blocks of a selected message source into an external sha3 core and latches its digest.
// Optional macro HASH_SEQ_CYCLE_CNT_EN adds a saturating cycle_cnt output covering SEND and WAIT.
module hash_block_sequencer #(
    parameter int unsigned BLOCK_W    = 1088,
    parameter int unsigned MAX_BLOCKS = 2,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DIGEST_W   = 512,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned MODE_W     = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [MODE_W-1:0]                     mode,
    input  logic [CNT_W-1:0]                      group_num,
    input  logic [NUM_SRC*MAX_BLOCKS*BLOCK_W-1:0] src_data,
    input  logic                                  hstart,
    input  logic                                  restart,
    output logic                                  core_start,
    output logic [BLOCK_W-1:0]                    core_block,
    output logic                                  core_block_valid,
    input  logic                                  core_block_ready,
    output logic                                  core_out_req,
    input  logic [DIGEST_W-1:0]                   core_digest,
    input  logic                                  core_digest_valid,
    output logic [DIGEST_W-1:0]                   hash_value,
    output logic                                  en_end,
    output logic                                  busy,
    output logic                                  err
`ifdef HASH_SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]                           cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [CNT_W-1:0]    group_q, group_d;
    logic [CNT_W-1:0]    blk_idx_q, blk_idx_d;
    logic                core_start_q, core_start_d;
    logic                err_q, err_d;
    logic                en_end_q, en_end_d;
    logic [DIGEST_W-1:0] hash_q, hash_d;
    logic [BLOCK_W-1:0]  block_sel;

    logic req_legal;
    logic accept;
    logic handshake;
    logic last_blk;
    logic digest_take;

    assign req_legal   = (group_num != '0) && (group_num <= CNT_W'(MAX_BLOCKS))
                         && (32'(mode) < NUM_SRC);
    assign accept      = (state_q == ST_IDLE) && hstart && req_legal;
    assign handshake   = (state_q == ST_SEND) && core_block_ready;
    assign last_blk    = (blk_idx_q == group_q - CNT_W'(1));
    assign digest_take = (state_q == ST_WAIT) && core_digest_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)                  state_d = ST_SEND;
            ST_SEND: if (handshake && last_blk)   state_d = ST_WAIT;
            ST_WAIT: if (core_digest_valid)       state_d = ST_DONE;
            ST_DONE: if (restart)                 state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Job parameters, block index and result registers.
    always_comb begin
        mode_d       = mode_q;
        group_d      = group_q;
        blk_idx_d    = blk_idx_q;
        core_start_d = accept;
        err_d        = (state_q == ST_IDLE) && hstart && !req_legal;
        en_end_d     = en_end_q;
        hash_d       = hash_q;
        if (accept) begin
            mode_d    = mode;
            group_d   = group_num;
            blk_idx_d = '0;
        end
        if (handshake) begin
            blk_idx_d = blk_idx_q + CNT_W'(1);
        end
        if (digest_take) begin
            hash_d   = core_digest;
            en_end_d = 1'b1;
        end else if ((state_q == ST_DONE) && restart) begin
            en_end_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the digest register is reset too, because hash_value must read 0 out of reset.
        if (reset) begin
            mode_q       <= '0;
            group_q      <= '0;
            blk_idx_q    <= '0;
            core_start_q <= 1'b0;
            err_q        <= 1'b0;
            en_end_q     <= 1'b0;
            hash_q       <= '0;
        end else begin
            mode_q       <= mode_d;
            group_q      <= group_d;
            blk_idx_q    <= blk_idx_d;
            core_start_q <= core_start_d;
            err_q        <= err_d;
            en_end_q     <= en_end_d;
            hash_q       <= hash_d;
        end
    end

    // Source/block mux from registered indices; out-of-range indices select nothing.
    always_comb begin
        block_sel = '0;
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            for (int b = 0; b < int'(MAX_BLOCKS); b++) begin
                if ((mode_q == MODE_W'(s)) && (blk_idx_q == CNT_W'(b))) begin
                    block_sel = src_data[(s*MAX_BLOCKS+b)*BLOCK_W +: BLOCK_W];
                end
            end
        end
    end

    // Output logic.
    always_comb begin
        core_block_valid = (state_q == ST_SEND);
        core_out_req     = (state_q == ST_WAIT);
        busy             = (state_q == ST_SEND) || (state_q == ST_WAIT);
        core_block       = (state_q == ST_SEND) ? block_sel : '0;
        core_start       = core_start_q;
        err              = err_q;
        en_end           = en_end_q;
        hash_value       = hash_q;
    end

`ifdef HASH_SEQ_CYCLE_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (((state_q == ST_SEND) || (state_q == ST_WAIT)) && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_hash_block_sequencer.sv
// Self-checking bench for hash_block_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the sequencer.
module tb_hash_block_sequencer;

    localparam int BW = 96;
    localparam int MB = 2;
    localparam int NS = 2;
    localparam int DW = 64;
    localparam int CW = 10;
    localparam int MW = 2;
    localparam int SW = NS * MB * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic [MW-1:0] mode;
    logic [CW-1:0] group_num;
    logic [SW-1:0] src_data;
    logic          hstart;
    logic          restart;
    logic          core_start;
    logic [BW-1:0] core_block;
    logic          core_block_valid;
    logic          core_block_ready;
    logic          core_out_req;
    logic [DW-1:0] core_digest;
    logic          core_digest_valid;
    logic [DW-1:0] hash_value;
    logic          en_end;
    logic          busy;
    logic          err;
`ifdef HASH_SEQ_CYCLE_CNT_EN
    logic [31:0]   cycle_cnt;
`endif

    always #5 clk = ~clk;

    hash_block_sequencer #(
        .BLOCK_W(BW), .MAX_BLOCKS(MB), .NUM_SRC(NS),
        .DIGEST_W(DW), .CNT_W(CW), .MODE_W(MW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mode              (mode),
        .group_num         (group_num),
        .src_data          (src_data),
        .hstart            (hstart),
        .restart           (restart),
        .core_start        (core_start),
        .core_block        (core_block),
        .core_block_valid  (core_block_valid),
        .core_block_ready  (core_block_ready),
        .core_out_req      (core_out_req),
        .core_digest       (core_digest),
        .core_digest_valid (core_digest_valid),
        .hash_value        (hash_value),
        .en_end            (en_end),
        .busy              (busy),
        .err               (err)
`ifdef HASH_SEQ_CYCLE_CNT_EN
        ,
        .cycle_cnt         (cycle_cnt)
`endif
    );

    int n_checks   = 0;
    int n_fail     = 0;
    int start_seen = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] src_blk(input int s, input int b);
        return src_data[(s*MB+b)*BW +: BW];
    endfunction

    task automatic fill_src();
        for (int i = 0; i < SW; i += 32) begin
            logic [31:0] w;
            w = $urandom;
            for (int k = 0; k < 32 && i + k < SW; k++) src_data[i+k] = w[k];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Transaction-level model: a job is either in flight (blocks accepted so far,
    // then awaiting the digest), finished (done flag set), or absent.
    bit            model_ok = 1'b0;
    bit            m_active, m_done, m_start, m_err;
    int            m_sent, m_n, m_mode;
    logic [DW-1:0] m_hash;
    logic [31:0]   m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            model_ok = 1'b1;
            m_active = 1'b0; m_done = 1'b0; m_start = 1'b0; m_err = 1'b0;
            m_sent = 0; m_n = 0; m_mode = 0; m_hash = '0; m_cnt = '0;
        end else begin
            m_start = 1'b0;
            m_err   = 1'b0;
            if (m_active) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_sent < m_n) begin
                    if (core_block_ready) m_sent++;
                end else if (core_digest_valid) begin
                    m_hash   = core_digest;
                    m_done   = 1'b1;
                    m_active = 1'b0;
                end
            end else if (m_done) begin
                if (restart) m_done = 1'b0;
            end else if (hstart) begin
                if (group_num >= 1 && group_num <= MB && int'(mode) < NS) begin
                    m_active = 1'b1;
                    m_sent   = 0;
                    m_n      = int'(group_num);
                    m_mode   = int'(mode);
                    m_start  = 1'b1;
                    m_cnt    = '0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (core_start) start_seen++;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            logic          exp_valid;
            logic [BW-1:0] exp_block;
            exp_valid = m_active && (m_sent < m_n);
            exp_block = exp_valid ? src_blk(m_mode, m_sent) : '0;
            check("busy",             busy,             m_active);
            check("core_block_valid", core_block_valid, exp_valid);
            check("core_out_req",     core_out_req,     m_active && (m_sent == m_n));
            check("core_block",       core_block,       exp_block);
            check("core_start",       core_start,       m_start);
            check("err",              err,              m_err);
            check("en_end",           en_end,           m_done);
            check("hash_value",       hash_value,       m_hash);
`ifdef HASH_SEQ_CYCLE_CNT_EN
            check("cycle_cnt",        cycle_cnt,        m_cnt);
`endif
        end
    end

    initial begin
        logic [DW-1:0] d1, d2;
        int s0;

        reset = 1'b1; mode = '0; group_num = '0; hstart = 1'b0; restart = 1'b0;
        core_block_ready = 1'b0; core_digest_valid = 1'b0;
        core_digest = {$urandom, $urandom};
        src_data = '0;
        fill_src();
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_en_end", en_end, 1'b0);
        check("rst_hash", hash_value, '0);
        check("rst_block", core_block, '0);
        check("rst_start", core_start, 1'b0);

        // Two-block job, ready and digest_valid high.
        d1 = {$urandom, $urandom};
        mode = 0; group_num = 2; core_block_ready = 1'b1; core_digest_valid = 1'b1;
        core_digest = d1; hstart = 1'b1; s0 = start_seen;
        tick(); hstart = 1'b0;
        @(negedge clk);
        check("t1_start_c1", core_start, 1'b1);
        check("t1_busy_c1", busy, 1'b1);
        check("t1_blk0", core_block, src_blk(0, 0));
        tick(); @(negedge clk);
        check("t1_blk1", core_block, src_blk(0, 1));
        check("t1_start_c2", core_start, 1'b0);
        tick(); @(negedge clk);
        check("t1_outreq_c3", core_out_req, 1'b1);
        check("t1_busy_c3", busy, 1'b1);
        check("t1_en_end_c3", en_end, 1'b0);
        tick(); @(negedge clk);
        check("t1_en_end_c4", en_end, 1'b1);
        check("t1_hash", hash_value, d1);
        check("t1_busy_c4", busy, 1'b0);
        check("t1_starts", start_seen - s0, 1);

        // One-block job with ready stalling for two cycles.
        restart = 1'b1; tick(); restart = 1'b0;
        d2 = {$urandom, $urandom};
        mode = 1; group_num = 1; core_block_ready = 1'b1; core_digest_valid = 1'b0;
        core_digest = d2; hstart = 1'b1; s0 = start_seen;
        tick(); hstart = 1'b0; core_block_ready = 1'b0;
        @(negedge clk);
        check("t2_blk_c1", core_block, src_blk(1, 0));
        tick(); @(negedge clk);
        check("t2_blk_c2", core_block, src_blk(1, 0));
        check("t2_valid_c2", core_block_valid, 1'b1);
        tick(); core_block_ready = 1'b1;
        @(negedge clk);
        check("t2_blk_c3", core_block, src_blk(1, 0));
        tick(); core_block_ready = 1'b0;
        @(negedge clk);
        check("t2_outreq", core_out_req, 1'b1);
        check("t2_valid_off", core_block_valid, 1'b0);
        core_digest_valid = 1'b1;
        tick(); core_digest_valid = 1'b0;
        @(negedge clk);
        check("t2_en_end", en_end, 1'b1);
        check("t2_hash", hash_value, d2);
        check("t2_starts", start_seen - s0, 1);

        // Illegal requests: group 0, group above MAX_BLOCKS, mode beyond NUM_SRC.
        restart = 1'b1; tick(); restart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode      = (i == 2) ? 2'd2 : 2'd0;
            group_num = (i == 0) ? 10'd0 : (i == 1) ? 10'd3 : 10'd1;
            hstart = 1'b1; s0 = start_seen;
            tick(); hstart = 1'b0;
            @(negedge clk);
            check("t3_err", err, 1'b1);
            check("t3_busy", busy, 1'b0);
            tick(); @(negedge clk);
            check("t3_err_pulse", err, 1'b0);
            check("t3_en_end", en_end, 1'b0);
            check("t3_no_start", start_seen - s0, 0);
        end

        // DONE ignores hstart; restart with hstart relaunches one cycle later.
        mode = 0; group_num = 1; core_block_ready = 1'b1; core_digest_valid = 1'b1;
        hstart = 1'b1; tick(); hstart = 1'b0; tick(); tick();
        @(negedge clk);
        check("t4_done", en_end, 1'b1);
        hstart = 1'b1; s0 = start_seen;
        repeat (5) begin
            tick(); @(negedge clk);
            check("t4_hold_en_end", en_end, 1'b1);
        end
        check("t4_no_start", start_seen - s0, 0);
        restart = 1'b1; tick(); restart = 1'b0;
        @(negedge clk);
        check("t4_cleared", en_end, 1'b0);
        check("t4_start_not_yet", core_start, 1'b0);
        tick(); hstart = 1'b0;
        @(negedge clk);
        check("t4_restart_start", core_start, 1'b1);
        tick(); tick(); tick();
        restart = 1'b1; tick(); restart = 1'b0;

        // Reset mid-SEND after block 0 accepted.
        mode = 0; group_num = 2; core_block_ready = 1'b1; core_digest_valid = 1'b0;
        hstart = 1'b1; tick(); hstart = 1'b0;
        tick(); reset = 1'b1; core_block_ready = 1'b0;
        tick(); reset = 1'b0;
        @(negedge clk);
        check("t5_busy", busy, 1'b0);
        check("t5_valid", core_block_valid, 1'b0);
        check("t5_outreq", core_out_req, 1'b0);
        check("t5_block", core_block, '0);
        check("t5_hash", hash_value, '0);
        mode = 1; group_num = 2; hstart = 1'b1;
        tick(); hstart = 1'b0;
        @(negedge clk);
        check("t5_fresh_blk0", core_block, src_blk(1, 0));
        core_block_ready = 1'b1; core_digest_valid = 1'b1;
        tick(); tick(); tick();
        restart = 1'b1; tick(); restart = 1'b0;

`ifdef HASH_SEQ_CYCLE_CNT_EN
        // Two blocks, digest_valid arriving five cycles after out_req rises.
        mode = 0; group_num = 2; core_block_ready = 1'b1; core_digest_valid = 1'b0;
        hstart = 1'b1; tick(); hstart = 1'b0;
        repeat (7) tick();
        core_digest_valid = 1'b1; tick(); core_digest_valid = 1'b0;
        @(negedge clk);
        check("t6_cnt_done", cycle_cnt, 32'd8);
        tick(); @(negedge clk);
        check("t6_cnt_hold", cycle_cnt, 32'd8);
        restart = 1'b1; tick(); restart = 1'b0;
`endif

        // Randomized traffic.
        repeat (3000) begin
            tick();
            reset             = ($urandom_range(0, 299) == 0);
            hstart            = ($urandom_range(0, 3) == 0);
            restart           = ($urandom_range(0, 5) == 0);
            mode              = ($urandom_range(0, 5) == 0) ? MW'($urandom_range(2, 3))
                                                            : MW'($urandom_range(0, 1));
            group_num         = ($urandom_range(0, 5) == 0) ? CW'($urandom_range(0, 5) * 3 % 7)
                                                            : CW'($urandom_range(1, 2));
            core_block_ready  = ($urandom_range(0, 2) != 0);
            core_digest_valid = ($urandom_range(0, 2) == 0);
            core_digest       = {$urandom, $urandom};
            if (!m_active) fill_src();
        end
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_block_sequencer.md
Name: hash_block_sequencer

Overview:
- Parametrised successor to the single-mode H-function front end.
- Selects one of NUM_SRC flattened message sources and streams 1..MAX_BLOCKS rate-width blocks to an external sha3 core over a valid/ready handshake.
- Requests the squeezed digest, latches it, and holds a sticky done flag until restart.
- Sits between the Picnic commitment/seed logic and the sha3 core. The core is connected through ports, not instantiated, so it can be swapped or modelled.

Parameters:
- BLOCK_W, 1088: absorb-block width in bits (SHAKE256 rate).
- MAX_BLOCKS, 2: maximum blocks per message per source.
- NUM_SRC, 2: number of selectable message sources (h1 seed set, h3 commitment, ...).
- DIGEST_W, 512: digest width in bits.
- CNT_W, 10: width of the block-count input.
- MODE_W, 1: width of the mode input; must satisfy 2^MODE_W >= NUM_SRC.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  MODE_W  source select, sampled at job accept.
- group_num  in  CNT_W  number of blocks in the job, sampled at accept; legal range 1..MAX_BLOCKS.
- src_data  in  NUM_SRC*MAX_BLOCKS*BLOCK_W  source s, block b at bits [(s*MAX_BLOCKS+b+1)*BLOCK_W-1 -: BLOCK_W].
- hstart  in  1  job request (level or pulse).
- restart  in  1  clears done and returns the block to IDLE.
- core_start  out  1  one-cycle pulse that opens a new absorb in the core.
- core_block  out  BLOCK_W  current block data.
- core_block_valid  out  1  core_block is valid.
- core_block_ready  in  1  core accepts core_block this cycle.
- core_out_req  out  1  level request for the digest.
- core_digest  in  DIGEST_W  digest from the core.
- core_digest_valid  in  1  core_digest is valid this cycle.
- hash_value  out  DIGEST_W  latched digest.
- en_end  out  1  sticky done flag.
- busy  out  1  high in SEND or WAIT.
- err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset values: all outputs 0; state IDLE; blk_idx 0; latched mode and group_num 0.
- Reset mid-job aborts immediately. core_block_valid and core_out_req drop the next edge; the core is not notified, and the system resets it alongside.
- States: IDLE, SEND, WAIT, DONE.
- IDLE + hstart + legal parameters (1 <= group_num <= MAX_BLOCKS, mode < NUM_SRC):
  - latch mode and group_num; blk_idx <= 0;
  - core_start <= 1 for exactly one cycle; go to SEND.
- IDLE + hstart + illegal parameters: err pulses 1 cycle; stay IDLE; nothing sent to the core.
- SEND:
  - core_block_valid = 1.
  - core_block = src_data[latched mode][blk_idx], combinational from registered indices.
  - On valid & ready, blk_idx increments.
  - On acceptance of block group_num-1: go to WAIT and set core_out_req = 1 the following cycle.
  - ready low stalls indefinitely; data is held stable.
- WAIT: core_out_req stays 1 until core_digest_valid. In that cycle: hash_value <= core_digest; en_end <= 1; core_out_req <= 0; go to DONE.
- DONE:
  - en_end and hash_value hold.
  - hstart without restart is ignored; no recompute.
  - restart: en_end <= 0, go to IDLE.
  - restart and hstart in the same cycle: en_end cleared that edge; the new job is accepted from IDLE on the next edge if hstart is still high.
- hstart and restart are ignored in SEND and WAIT.
- core_digest_valid outside WAIT is ignored.
- src_data must be stable from accept until the last block is accepted. The block does not buffer src_data.
- Latency with ready and digest_valid tied high:
  - accept at edge 0;
  - core_start and block 0 at cycle 1;
  - block N-1 accepted at cycle N;
  - out_req at cycle N+1;
  - en_end visible at cycle N+2.
- hash_value retains the previous digest until overwritten by the next job.

Optional Feature:
- HASH_SEQ_CYCLE_CNT_EN defined:
  - adds output cycle_cnt [31:0];
  - cleared at job accept; increments every cycle in SEND and WAIT; saturates at 32'hFFFFFFFF;
  - frozen in DONE; 0 after reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- mode=0, group_num=2, ready=1, digest_valid one cycle after out_req -> exactly one core_start pulse; core_block equals src block 0 then block 1; en_end=1 at cycle 4 with hash_value equal to the core digest; busy high cycles 1-3.
- mode=1, group_num=1, ready toggling 1/0/0/1 -> block held stable while ready=0; exactly one handshake; en_end asserts; no second core_start.
- group_num=0, then group_num=3 with MAX_BLOCKS=2, then mode=2 with NUM_SRC=2 -> err pulse each time; state stays IDLE; no core_start; en_end stays 0.
- In DONE: hstart=1 without restart for 5 cycles -> no core_start; en_end stays 1. Then restart and hstart together -> en_end=0 next edge; a new core_start follows one cycle later.
- reset=1 mid-SEND, after block 0 accepted -> next edge: all outputs 0, state IDLE; a fresh job afterwards starts again from block 0.
- With HASH_SEQ_CYCLE_CNT_EN, group_num=2, digest_valid delayed by 5 cycles -> cycle_cnt=8 at DONE and held there.
